ahbl_req_master: RTL and testbench

//  Single-outstanding AHB-lite manager. Converts a valid/ready request port

---
 rtl/ahbl_req_master_if.sv | 48 ++++
 rtl/ahbl_req_master.sv | 159 +++++++++++++++
 tb/tb_ahbl_req_master.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahbl_req_master_if.sv
// Request/response port and AHB-lite manager bus for ahbl_req_master.
// Handshake: a request transfers on a posedge where req_valid & req_ready are both 1; rsp_valid is a one-cycle strobe that needs no ready.
interface ahbl_req_master_if #(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [W_ADDR-1:0] req_addr;
  logic [1:0]        req_size;
  logic [W_DATA-1:0] req_wdata;
  logic              req_excl;
  logic              rsp_valid;
  logic [W_DATA-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_exokay;
  logic [W_ADDR-1:0] ahbm_haddr;
  logic              ahbm_hwrite;
  logic [1:0]        ahbm_htrans;
  logic [2:0]        ahbm_hsize;
  logic [2:0]        ahbm_hburst;
  logic [3:0]        ahbm_hprot;
  logic              ahbm_hmastlock;
  logic              ahbm_hexcl;
  logic [7:0]        ahbm_hmaster;
  logic [W_DATA-1:0] ahbm_hwdata;
  logic              ahbm_hready;
  logic              ahbm_hresp;
  logic [W_DATA-1:0] ahbm_hrdata;
  logic              ahbm_hexokay;

  modport master (
    input  req_valid, req_write, req_addr, req_size, req_wdata, req_excl,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_exokay,
    output ahbm_haddr, ahbm_hwrite, ahbm_htrans, ahbm_hsize, ahbm_hburst,
    output ahbm_hprot, ahbm_hmastlock, ahbm_hexcl, ahbm_hmaster, ahbm_hwdata,
    input  ahbm_hready, ahbm_hresp, ahbm_hrdata, ahbm_hexokay
  );

  modport slave (
    output req_valid, req_write, req_addr, req_size, req_wdata, req_excl,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_exokay,
    input  ahbm_haddr, ahbm_hwrite, ahbm_htrans, ahbm_hsize, ahbm_hburst,
    input  ahbm_hprot, ahbm_hmastlock, ahbm_hexcl, ahbm_hmaster, ahbm_hwdata,
    output ahbm_hready, ahbm_hresp, ahbm_hrdata, ahbm_hexokay
  );
endinterface

// File: rtl/ahbl_req_master.sv
// Single-outstanding AHB-lite manager: turns one valid/ready request into one
// NONSEQ transfer (with exclusive support) and returns a one-cycle response.
module ahbl_req_master #(
  parameter int         W_ADDR     = 32,
  parameter int         W_DATA     = 32,
  parameter logic [7:0] HMASTER_ID = 8'h00,
  parameter logic [3:0] HPROT      = 4'b0011
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ahbl_req_master_if.master    bus,
  output logic [1:0]           o_dbg_state
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_APH  = 2'd1,
    S_DPH  = 2'd2,
    S_RSP  = 2'd3
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  state_t            r_state;
  logic              r_req_ready;
  logic [W_ADDR-1:0] r_haddr;
  logic              r_hwrite;
  logic [1:0]        r_size;
  logic              r_hexcl;
  logic [1:0]        r_htrans;
  logic [W_DATA-1:0] r_hwdata;
  logic              r_rsp_valid;
  logic [W_DATA-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic              r_rsp_exokay;

  logic              w_accept;
  logic              w_illegal;
  logic [W_DATA-1:0] w_wdata_rep;
  logic [W_DATA-1:0] w_rdata_shift;
  logic [W_DATA-1:0] w_rdata_lane;

  assign w_accept = bus.req_valid & r_req_ready;

  // Size 3 and addresses not aligned to the access size never reach the bus.
  always_comb begin
    w_illegal = 1'b0;
    case (bus.req_size)
      2'd1:    w_illegal = bus.req_addr[0];
      2'd2:    w_illegal = (bus.req_addr[1:0] != 2'b00);
      2'd3:    w_illegal = 1'b1;
      default: w_illegal = 1'b0;
    endcase
  end

  always_comb begin
    w_wdata_rep = bus.req_wdata;
    case (bus.req_size)
      2'd0:    w_wdata_rep = {4{bus.req_wdata[7:0]}};
      2'd1:    w_wdata_rep = {2{bus.req_wdata[15:0]}};
      default: w_wdata_rep = bus.req_wdata;
    endcase
  end

  // Read lanes are right-justified from the byte offset, then zero-extended.
  assign w_rdata_shift = bus.ahbm_hrdata >> {r_haddr[1:0], 3'b000};

  always_comb begin
    w_rdata_lane = w_rdata_shift;
    case (r_size)
      2'd0:    w_rdata_lane = {{(W_DATA-8){1'b0}}, w_rdata_shift[7:0]};
      2'd1:    w_rdata_lane = {{(W_DATA-16){1'b0}}, w_rdata_shift[15:0]};
      default: w_rdata_lane = w_rdata_shift;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_req_ready  <= 1'b0;
      r_haddr      <= '0;
      r_hwrite     <= 1'b0;
      r_size       <= 2'd0;
      r_hexcl      <= 1'b0;
      r_htrans     <= HTRANS_IDLE;
      r_hwdata     <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_rdata  <= '0;
      r_rsp_err    <= 1'b0;
      r_rsp_exokay <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_req_ready <= 1'b1;
          if (w_accept) begin
            r_req_ready <= 1'b0;
            if (w_illegal) begin
              r_state      <= S_RSP;
              r_rsp_valid  <= 1'b1;
              r_rsp_err    <= 1'b1;
              r_rsp_exokay <= 1'b0;
              r_rsp_rdata  <= '0;
            end else begin
              r_state  <= S_APH;
              r_htrans <= HTRANS_NONSEQ;
              r_haddr  <= bus.req_addr;
              r_hwrite <= bus.req_write;
              r_size   <= bus.req_size;
              r_hexcl  <= bus.req_excl;
              r_hwdata <= w_wdata_rep;
            end
          end
        end
        S_APH: begin
          if (bus.ahbm_hready) begin
            r_state  <= S_DPH;
            r_htrans <= HTRANS_IDLE;
          end
        end
        S_DPH: begin
          // The first ERROR cycle has hready low and simply waits here.
          if (bus.ahbm_hready) begin
            r_state      <= S_RSP;
            r_rsp_valid  <= 1'b1;
            r_rsp_err    <= bus.ahbm_hresp;
            r_rsp_exokay <= r_hexcl & bus.ahbm_hexokay & ~bus.ahbm_hresp;
            r_rsp_rdata  <= (bus.ahbm_hresp | r_hwrite) ? '0 : w_rdata_lane;
          end
        end
        S_RSP: begin
          r_state      <= S_IDLE;
          r_req_ready  <= 1'b1;
          r_rsp_err    <= 1'b0;
          r_rsp_exokay <= 1'b0;
          r_rsp_rdata  <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready      = r_req_ready;
  assign bus.rsp_valid      = r_rsp_valid;
  assign bus.rsp_rdata      = r_rsp_rdata;
  assign bus.rsp_err        = r_rsp_err;
  assign bus.rsp_exokay     = r_rsp_exokay;
  assign bus.ahbm_haddr     = r_haddr;
  assign bus.ahbm_hwrite    = r_hwrite;
  assign bus.ahbm_htrans    = r_htrans;
  assign bus.ahbm_hsize     = {1'b0, r_size};
  assign bus.ahbm_hburst    = 3'b000;
  assign bus.ahbm_hprot     = HPROT;
  assign bus.ahbm_hmastlock = 1'b0;
  assign bus.ahbm_hexcl     = r_hexcl;
  assign bus.ahbm_hmaster   = HMASTER_ID;
  assign bus.ahbm_hwdata    = r_hwdata;
  assign o_dbg_state        = r_state;
endmodule

// File: tb/tb_ahbl_req_master.sv
// Self-checking bench for ahbl_req_master: directed scenarios plus random
// requests against a slave model and a behavioural response model.
module tb_ahbl_req_master;
  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         total;
  int         bad;
  logic [31:0] exp_q[$];

  typedef struct {
    int          lat;
    int          nrsp;
    int          nnonseq;
    int          dph_bad;
    logic [31:0] rdata;
    logic        err;
    logic        exokay;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic        hexcl;
    logic [31:0] hwdata;
    logic        timeout;
  } obs_t;

  ahbl_req_master_if #(.W_ADDR(32), .W_DATA(32)) bus ();

  ahbl_req_master #(
    .W_ADDR(32), .W_DATA(32), .HMASTER_ID(8'h00), .HPROT(4'b0011)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic m_illegal(input logic [31:0] addr, input logic [1:0] size);
    if (size == 2'd3) return 1'b1;
    if (size == 2'd1 && (addr % 2) != 0) return 1'b1;
    if (size == 2'd2 && (addr % 4) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_rdata(input logic wr, input logic [31:0] addr,
      input logic [1:0] size, input logic [31:0] hrd, input logic berr);
    longint unsigned v;
    longint unsigned nbytes;
    if (m_illegal(addr, size) || wr || berr) return 32'h0;
    nbytes = longint'(1) << size;
    v = hrd;
    v = v / (64'd1 << (8 * (addr % 4)));
    v = v % (64'd1 << (8 * nbytes));
    return v[31:0];
  endfunction

  function automatic logic [31:0] m_hwdata(input logic [31:0] wdata, input logic [1:0] size);
    if (size == 2'd0) return {24'h0, wdata[7:0]} * 32'h0101_0101;
    if (size == 2'd1) return {16'h0, wdata[15:0]} * 32'h0001_0001;
    return wdata;
  endfunction

  function automatic int m_lat(input logic ill, input int waits, input logic berr);
    if (ill) return 1;
    return 3 + waits + (berr ? 1 : 0);
  endfunction

  // ---------------- driver + slave model ----------------
  task automatic run_req(input logic wr, input logic [31:0] addr, input logic [1:0] size,
      input logic [31:0] wdata, input logic excl, input int waits, input logic berr,
      input logic [31:0] hrd, input logic xok, output obs_t o);
    int guard;
    int phase;
    int dj;
    o.lat = 0; o.nrsp = 0; o.nnonseq = 0; o.dph_bad = 0; o.rdata = '0; o.err = 1'b0;
    o.exokay = 1'b0; o.haddr = '0; o.hwrite = 1'b0; o.hsize = '0; o.hexcl = 1'b0;
    o.hwdata = '0; o.timeout = 1'b0;
    @(negedge clk);
    guard = 0;
    while (bus.req_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      o.timeout = 1'b1;
      return;
    end
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_size  = size;
    bus.req_wdata = wdata;
    bus.req_excl  = excl;
    @(posedge clk);
    phase = 0;
    dj = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) bus.req_valid = 1'b0;
      if (bus.rsp_valid === 1'b1) begin
        o.nrsp++;
        if (o.nrsp == 1) begin
          o.lat = k; o.rdata = bus.rsp_rdata; o.err = bus.rsp_err; o.exokay = bus.rsp_exokay;
        end
      end
      if (bus.ahbm_htrans === 2'b10) begin
        o.nnonseq++;
        if (phase != 0) o.dph_bad++;
      end else if (bus.ahbm_htrans !== 2'b00) begin
        o.dph_bad++;
      end
      case (phase)
        0: begin
          bus.ahbm_hready = 1'b1; bus.ahbm_hresp = 1'b0;
          if (bus.ahbm_htrans === 2'b10) begin
            o.haddr = bus.ahbm_haddr; o.hwrite = bus.ahbm_hwrite;
            o.hsize = bus.ahbm_hsize; o.hexcl = bus.ahbm_hexcl;
            phase = 1;
          end
        end
        1: begin
          bus.ahbm_hrdata = $urandom;
          bus.ahbm_hexokay = 1'b0;
          if (dj < waits) begin
            bus.ahbm_hready = 1'b0; bus.ahbm_hresp = 1'b0;
          end else if (berr && dj == waits) begin
            bus.ahbm_hready = 1'b0; bus.ahbm_hresp = 1'b1;
          end else begin
            bus.ahbm_hready = 1'b1; bus.ahbm_hresp = berr;
            bus.ahbm_hrdata = hrd; bus.ahbm_hexokay = xok;
            o.hwdata = bus.ahbm_hwdata;
            phase = 2;
          end
          dj++;
        end
        default: begin
          bus.ahbm_hready = 1'b1; bus.ahbm_hresp = 1'b0;
          bus.ahbm_hrdata = $urandom; bus.ahbm_hexokay = 1'b0;
        end
      endcase
      if (o.nrsp > 0 && k >= o.lat + 2) break;
    end
    if (o.nrsp == 0) o.timeout = 1'b1;
    bus.ahbm_hready = 1'b1;
    bus.ahbm_hresp  = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_size = '0;
    bus.req_wdata = '0; bus.req_excl = 1'b0;
    bus.ahbm_hready = 1'b1; bus.ahbm_hresp = 1'b0; bus.ahbm_hrdata = '0; bus.ahbm_hexokay = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.ahbm_htrans, bus.ahbm_haddr, bus.ahbm_hwrite, bus.ahbm_hexcl, bus.ahbm_hwdata} !== 68'h0) begin
      bad++;
      $display("FAIL reset_bus got htrans=%0h haddr=%h hwrite=%0b hexcl=%0b hwdata=%h want all 0",
               bus.ahbm_htrans, bus.ahbm_haddr, bus.ahbm_hwrite, bus.ahbm_hexcl, bus.ahbm_hwdata);
    end
    total++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_exokay, bus.rsp_rdata} !== 36'h0) begin
      bad++;
      $display("FAIL reset_rsp got ready=%0b valid=%0b err=%0b exokay=%0b rdata=%h want all 0",
               bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_exokay, bus.rsp_rdata);
    end
    total++;
    if ({bus.ahbm_hburst, bus.ahbm_hprot, bus.ahbm_hmastlock, bus.ahbm_hmaster} !== {3'b000, 4'b0011, 1'b0, 8'h00}) begin
      bad++;
      $display("FAIL reset_const got hburst=%0h hprot=%0h hmastlock=%0b hmaster=%0h want 0/3/0/0",
               bus.ahbm_hburst, bus.ahbm_hprot, bus.ahbm_hmastlock, bus.ahbm_hmaster);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (bus.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready_after got=%0b want=1", bus.req_ready);
    end
  endtask

  task automatic test_word_read;
    obs_t o;
    run_req(1'b0, 32'h8000_0010, 2'd2, 32'h0, 1'b0, 0, 1'b0, 32'hDEAD_BEEF, 1'b0, o);
    total++;
    if (o.timeout || o.lat != 3) begin
      bad++; $display("FAIL word_read_lat got=%0d timeout=%0b want=3", o.lat, o.timeout);
    end
    total++;
    if (o.rdata !== 32'hDEAD_BEEF || o.err !== 1'b0) begin
      bad++; $display("FAIL word_read_data got rdata=%h err=%0b want DEADBEEF/0", o.rdata, o.err);
    end
    total++;
    if (o.haddr !== 32'h8000_0010 || o.hsize !== 3'd2 || o.hwrite !== 1'b0 || o.nnonseq != 1) begin
      bad++;
      $display("FAIL word_read_aph got haddr=%h hsize=%0d hwrite=%0b nonseq=%0d want 80000010/2/0/1",
               o.haddr, o.hsize, o.hwrite, o.nnonseq);
    end
  endtask

  task automatic test_byte_write_waits;
    obs_t o;
    run_req(1'b1, 32'h8000_0013, 2'd0, 32'h0000_00A5, 1'b0, 2, 1'b0, 32'h1111_2222, 1'b0, o);
    total++;
    if (o.timeout || o.lat != 5) begin
      bad++; $display("FAIL byte_write_lat got=%0d timeout=%0b want=5", o.lat, o.timeout);
    end
    total++;
    if (o.hsize !== 3'd0 || o.hwdata !== 32'hA5A5_A5A5 || o.hwrite !== 1'b1) begin
      bad++;
      $display("FAIL byte_write_bus got hsize=%0d hwdata=%h hwrite=%0b want 0/A5A5A5A5/1",
               o.hsize, o.hwdata, o.hwrite);
    end
    total++;
    if (o.rdata !== 32'h0 || o.err !== 1'b0 || o.nrsp != 1) begin
      bad++;
      $display("FAIL byte_write_rsp got rdata=%h err=%0b nrsp=%0d want 0/0/1", o.rdata, o.err, o.nrsp);
    end
  endtask

  task automatic test_half_read;
    obs_t o;
    run_req(1'b0, 32'h8000_0002, 2'd1, 32'h0, 1'b0, 0, 1'b0, 32'h1234_5678, 1'b0, o);
    total++;
    if (o.rdata !== 32'h0000_1234 || o.err !== 1'b0 || o.hsize !== 3'd1) begin
      bad++;
      $display("FAIL half_read got rdata=%h err=%0b hsize=%0d want 00001234/0/1", o.rdata, o.err, o.hsize);
    end
  endtask

  task automatic test_excl;
    obs_t o;
    run_req(1'b0, 32'h8000_0040, 2'd2, 32'h0, 1'b1, 0, 1'b0, 32'hCAFE_F00D, 1'b1, o);
    total++;
    if (o.exokay !== 1'b1 || o.hexcl !== 1'b1 || o.err !== 1'b0 || o.rdata !== 32'hCAFE_F00D) begin
      bad++;
      $display("FAIL excl_read got exokay=%0b hexcl=%0b err=%0b rdata=%h want 1/1/0/CAFEF00D",
               o.exokay, o.hexcl, o.err, o.rdata);
    end
    run_req(1'b1, 32'h8000_0040, 2'd2, 32'h0BAD_0001, 1'b1, 1, 1'b0, 32'h0, 1'b0, o);
    total++;
    if (o.exokay !== 1'b0 || o.err !== 1'b0 || o.hexcl !== 1'b1 || o.nrsp != 1) begin
      bad++;
      $display("FAIL excl_write_fail got exokay=%0b err=%0b hexcl=%0b nrsp=%0d want 0/0/1/1",
               o.exokay, o.err, o.hexcl, o.nrsp);
    end
  endtask

  task automatic test_errors;
    obs_t o;
    run_req(1'b0, 32'h8000_0020, 2'd2, 32'h0, 1'b1, 0, 1'b1, 32'h5555_AAAA, 1'b1, o);
    total++;
    if (o.err !== 1'b1 || o.rdata !== 32'h0 || o.exokay !== 1'b0 || o.lat != 4) begin
      bad++;
      $display("FAIL bus_error got err=%0b rdata=%h exokay=%0b lat=%0d want 1/0/0/4",
               o.err, o.rdata, o.exokay, o.lat);
    end
    total++;
    if (o.dph_bad != 0 || o.nnonseq != 1) begin
      bad++;
      $display("FAIL bus_error_htrans got dph_bad=%0d nonseq=%0d want 0/1", o.dph_bad, o.nnonseq);
    end
    run_req(1'b0, 32'h8000_0002, 2'd2, 32'h0, 1'b0, 0, 1'b0, 32'h7777_7777, 1'b0, o);
    total++;
    if (o.err !== 1'b1 || o.nnonseq != 0 || o.rdata !== 32'h0 || o.lat != 1) begin
      bad++;
      $display("FAIL misaligned got err=%0b nonseq=%0d rdata=%h lat=%0d want 1/0/0/1",
               o.err, o.nnonseq, o.rdata, o.lat);
    end
  endtask

  task automatic test_reset_mid_aph;
    obs_t o;
    int   guard;
    int   nrsp;
    @(negedge clk);
    guard = 0;
    while (bus.req_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h8000_0100;
    bus.req_size = 2'd2; bus.req_excl = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.ahbm_hready = 1'b0;
    total++;
    if (bus.ahbm_htrans !== 2'b10) begin
      bad++; $display("FAIL rst_aph_nonseq got htrans=%0h want 2", bus.ahbm_htrans);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.ahbm_htrans !== 2'b00 || bus.req_ready !== 1'b0) begin
      bad++;
      $display("FAIL rst_aph_idle got htrans=%0h ready=%0b want 0/0", bus.ahbm_htrans, bus.req_ready);
    end
    nrsp = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) nrsp++;
    end
    rst_n = 1'b1;
    bus.ahbm_hready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) nrsp++;
    end
    total++;
    if (nrsp != 0) begin
      bad++; $display("FAIL rst_aph_norsp got rsp_count=%0d want 0", nrsp);
    end
    run_req(1'b0, 32'h8000_0104, 2'd2, 32'h0, 1'b0, 0, 1'b0, 32'h0123_4567, 1'b0, o);
    total++;
    if (o.timeout || o.lat != 3 || o.rdata !== 32'h0123_4567 || o.err !== 1'b0) begin
      bad++;
      $display("FAIL rst_aph_next got lat=%0d rdata=%h err=%0b want 3/01234567/0", o.lat, o.rdata, o.err);
    end
  endtask

  task automatic test_random;
    obs_t        o;
    logic        wr, excl, berr, xok, ill;
    logic [31:0] addr, wdata, hrd, exp_rd;
    logic [1:0]  size;
    int          waits;
    for (int n = 0; n < 60; n++) begin
      wr    = 1'($urandom_range(0, 1));
      excl  = 1'($urandom_range(0, 1));
      xok   = 1'($urandom_range(0, 1));
      berr  = ($urandom_range(0, 5) == 0);
      waits = $urandom_range(0, 3);
      size  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      addr  = $urandom;
      if ($urandom_range(0, 3) != 0) addr = addr - (addr % (32'd1 << size));
      wdata = $urandom;
      hrd   = $urandom;
      ill   = m_illegal(addr, size);
      exp_q.push_back(m_rdata(wr, addr, size, hrd, berr));
      run_req(wr, addr, size, wdata, excl, waits, berr, hrd, xok, o);
      exp_rd = exp_q.pop_front();
      total++;
      if (o.timeout || o.nrsp != 1 || o.lat != m_lat(ill, waits, berr)) begin
        bad++;
        $display("FAIL rnd%0d_timing got lat=%0d nrsp=%0d timeout=%0b want lat=%0d nrsp=1",
                 n, o.lat, o.nrsp, o.timeout, m_lat(ill, waits, berr));
      end
      total++;
      if (o.rdata !== exp_rd || o.err !== (ill | berr) || o.exokay !== (excl & xok & ~berr & ~ill)) begin
        bad++;
        $display("FAIL rnd%0d_rsp got rdata=%h err=%0b exokay=%0b want %h/%0b/%0b", n, o.rdata,
                 o.err, o.exokay, exp_rd, ill | berr, excl & xok & ~berr & ~ill);
      end
      total++;
      if (o.nnonseq != (ill ? 0 : 1) || o.dph_bad != 0) begin
        bad++;
        $display("FAIL rnd%0d_htrans got nonseq=%0d dph_bad=%0d want %0d/0", n, o.nnonseq,
                 o.dph_bad, ill ? 0 : 1);
      end
      if (!ill) begin
        total++;
        if (o.haddr !== addr || o.hsize !== {1'b0, size} || o.hwrite !== wr || o.hexcl !== excl) begin
          bad++;
          $display("FAIL rnd%0d_aph got haddr=%h hsize=%0d hwrite=%0b hexcl=%0b want %h/%0d/%0b/%0b",
                   n, o.haddr, o.hsize, o.hwrite, o.hexcl, addr, size, wr, excl);
        end
        if (wr) begin
          total++;
          if (o.hwdata !== m_hwdata(wdata, size)) begin
            bad++;
            $display("FAIL rnd%0d_hwdata got=%h want=%h", n, o.hwdata, m_hwdata(wdata, size));
          end
        end
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_word_read();
    test_byte_write_waits();
    test_half_read();
    test_excl();
    test_errors();
    test_reset_mid_aph();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
